// File: rtl/tile_drain_if.sv
// Result stream from the tile drain toward the host/memory side.
// One snapshot element per beat, tagged with its tile coordinates.
interface tile_drain_if #(
    parameter int TILE_SIZE = 8,
    parameter int DATA_W    = 16
);
    localparam int RC_W = $clog2(TILE_SIZE);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [RC_W-1:0]   row;
    logic [RC_W-1:0]   col;
    logic              last;

    modport master (output valid, data, row, col, last, input ready);
    modport slave  (input valid, data, row, col, last, output ready);
endinterface

// File: rtl/tile_drain.sv
// Waits out the tile compute window, snapshots all Y results in one cycle,
// then streams them row-major over a valid/ready interface.
module tile_drain #(
    parameter int TILE_SIZE      = 8,
    parameter int DATA_W         = 16,
    parameter int COMPUTE_CYCLES = 25
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 en_i,
    input  logic                                 start_i,
    input  logic [TILE_SIZE*TILE_SIZE*DATA_W-1:0] y_flat_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    tile_drain_if.master                         out_if
);
    localparam int NUM   = TILE_SIZE * TILE_SIZE;
    localparam int RC_W  = $clog2(TILE_SIZE);
    // TILE_SIZE is a power of two, so index splits cleanly into {row, col}
    localparam int IDX_W = 2 * RC_W;
    localparam int CNT_W = $clog2(COMPUTE_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMPUTE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM} state_e;

    state_e                        state_q;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [NUM-1:0][DATA_W-1:0]    snap_q;
    logic                          valid_q, busy_q, done_q;

    assign cnt_d = cnt_q + CNT_W'(1);
    assign idx_d = idx_q + IDX_W'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // EN stretches the window; capture happens on the last counted edge
                    if (en_i) begin
                        if (cnt_q == CNT_LAST) begin
                            snap_q  <= y_flat_i;
                            idx_q   <= '0;
                            valid_q <= 1'b1;
                            state_q <= S_STREAM;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                S_STREAM: begin
                    if (out_if.ready) begin
                        if (idx_q == IDX_LAST) begin
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Payload is forced to zero whenever no beat is offered
    assign out_if.valid = valid_q;
    assign out_if.data  = valid_q ? snap_q[idx_q] : '0;
    assign out_if.row   = valid_q ? idx_q[IDX_W-1:RC_W] : '0;
    assign out_if.col   = valid_q ? idx_q[RC_W-1:0] : '0;
    assign out_if.last  = valid_q && (idx_q == IDX_LAST);
    assign busy_o       = busy_q;
    assign done_o       = done_q;
endmodule

// File: tb/tb_tile_drain.sv
// Scoreboard bench for tile_drain: stimulus queues expected beats, a negedge
// monitor compares every offered beat against the queue head.
module tb_tile_drain;
    localparam int TS = 8;
    localparam int DW = 16;
    localparam int N  = TS * TS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              en = 1'b1;
    logic              start = 1'b0;
    logic [N*DW-1:0]   y_flat = '0;
    logic              busy, done;
    logic              rdy = 1'b1;
    bit                rdy_mode = 1'b0;
    int                phase = 0;

    int errors = 0;
    int checks = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    logic [22:0] q[$];

    tile_drain_if #(.TILE_SIZE(TS), .DATA_W(DW)) oif ();
    assign oif.ready = rdy;

    tile_drain #(.TILE_SIZE(TS), .DATA_W(DW), .COMPUTE_CYCLES(25)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .en_i     (en),
        .start_i  (start),
        .y_flat_i (y_flat),
        .busy_o   (busy),
        .done_o   (done),
        .out_if   (oif)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Ready pattern 1,0,0,1 repeating when rdy_mode is set, else always ready
    always @(posedge clk) begin
        #1;
        rdy   = rdy_mode ? (phase == 0 || phase == 3) : 1'b1;
        phase = (phase + 1) % 4;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (oif.valid) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    check("beat", {9'd0, oif.data, oif.row, oif.col, oif.last}, {9'd0, q[0]});
                    if (rdy) begin
                        void'(q.pop_front());
                        beat_cnt++;
                    end
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic load_y();
        for (int k = 0; k < N; k++) y_flat[k*DW +: DW] = 16'h0100 + 16'(k);
    endtask

    task automatic push_expected();
        for (int k = 0; k < N; k++)
            q.push_back({16'h0100 + 16'(k), 3'(k / TS), 3'(k % TS), (k == N - 1)});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_tile(input int exp_lat, input bit en_gap, input bit extra_start, input bit corrupt);
        int  b0, d0, n;
        bit  seen;
        b0 = beat_cnt;
        d0 = done_cnt;
        load_y();
        push_expected();
        pulse_start();
        seen = 1'b0;
        for (n = 1; n <= 100; n++) begin
            en    = !(en_gap && n >= 3 && n < 8);
            start = extra_start && (n == 10);
            @(posedge clk); #1;
            if (oif.valid) begin seen = 1'b1; break; end
        end
        start = 1'b0;
        en    = 1'b1;
        check("first_valid_latency", seen ? 32'(n) : 32'd0, 32'(exp_lat));
        if (corrupt) begin
            @(posedge clk); #1 y_flat = '1;
        end
        seen = 1'b0;
        for (int m = 0; m < 1000; m++) begin
            start = extra_start && (m == 5);
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("busy_with_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("beat_count", 32'(beat_cnt - b0), 32'd64);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("sb_empty", 32'(q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(oif.valid), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_data"},  32'(oif.data), 32'd0);
        check({tag, "_last"},  32'(oif.last), 32'd0);
    endtask

    initial begin
        int  b0;
        bit  hit;
        // asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        rdy_mode = 1'b0;
        run_tile(25, 1'b0, 1'b0, 1'b0);

        rdy_mode = 1'b1;
        run_tile(25, 1'b0, 1'b0, 1'b1);

        rdy_mode = 1'b0;
        run_tile(30, 1'b1, 1'b1, 1'b0);

        // abort mid-stream after beat 10 has been accepted
        b0 = beat_cnt;
        load_y();
        push_expected();
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (beat_cnt - b0 >= 11) begin hit = 1'b1; break; end
        end
        check("abort_reached_beat10", 32'(hit), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        check("abort_beats_seen", 32'(beat_cnt - b0), 32'd11);
        q.delete();
        run_tile(25, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
